// File: rtl/pattern_sequencer_pkg.sv
// Shared types for the pattern sequencer.
// - mode_t : 2-bit playback mode (forward, reverse, ping-pong, one-shot)
// - dir_t  : ping-pong travel direction
package sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_FWD     = 2'b00,
    MODE_REV     = 2'b01,
    MODE_PING    = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/pattern_sequencer_channel.sv
// seq_channel: one record/playback channel.
// Holds the pattern memory, the recorded-length counter, the playback
// pointer/direction/one-shot FSM and the registered step output.
// Ports:
//   clock, Reset      : system clock, async active-low reset
//   step_tick         : playback advance strobe
//   wr_en, wr_data    : append one step (already edge-qualified by the top)
//   clr               : empty this channel
//   run, mode         : playback enable and step rule
//   display           : registered current step (0 when idle)
//   len               : number of recorded steps
//   playing           : actively stepping
//
// state                | meaning
// idle (run=0)         | ptr=0, dir=up, done=0, display forced to 0
// arm (run just rose)  | ptr loaded with start step, tick ignored
// step, dir=DIR_UP     | advancing toward len-1
// step, dir=DIR_DOWN   | ping-pong returning toward 0
// done                 | one-shot finished, holds last step until run falls/clear
module seq_channel
  import sequencer_pkg::*;
#(
  parameter int WORD_SIZE    = 2,
  parameter int ADDRESS_SIZE = 4,
  parameter int MEMORY_QTY   = 16
) (
  input  logic                  clock,
  input  logic                  Reset,
  input  logic                  step_tick,
  input  logic                  wr_en,
  input  logic [WORD_SIZE-1:0]  wr_data,
  input  logic                  clr,
  input  logic                  run,
  input  mode_t                 mode,
  output logic [WORD_SIZE-1:0]  display,
  output logic [ADDRESS_SIZE:0] len,
  output logic                  playing
);

  localparam logic [ADDRESS_SIZE:0]   LEN_FULL = (ADDRESS_SIZE+1)'(MEMORY_QTY);
  localparam logic [ADDRESS_SIZE:0]   LEN_ONE  = (ADDRESS_SIZE+1)'(1);
  localparam logic [ADDRESS_SIZE-1:0] PTR_ONE  = ADDRESS_SIZE'(1);

  logic [WORD_SIZE-1:0]    mem [MEMORY_QTY];
  logic [ADDRESS_SIZE-1:0] ptr;
  dir_t                    dir;
  logic                    done;
  logic                    run_q;
  logic [ADDRESS_SIZE:0]   len_m1;
  logic [ADDRESS_SIZE:0]   ptr_ext;
  logic                    has_steps;
  logic                    at_end;
  logic                    wr_ok;

  // len-1 is kept at full len width so the compare against ptr never truncates
  assign has_steps = (len != '0);
  assign len_m1    = len - LEN_ONE;
  assign ptr_ext   = {1'b0, ptr};
  assign at_end    = (ptr_ext >= len_m1);
  assign wr_ok     = wr_en & ~clr & (len != LEN_FULL);
  assign playing   = run & has_steps & ~done;

  // Memory is never reset; len gates what can be shown.
  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem[len[ADDRESS_SIZE-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      len     <= '0;
      ptr     <= '0;
      dir     <= DIR_UP;
      done    <= 1'b0;
      run_q   <= 1'b0;
      display <= '0;
    end else begin
      run_q <= run;
      // run_q term delays the first shown step to one cycle after the run rise
      display <= (run && run_q && has_steps) ? mem[ptr] : '0;

      if (wr_ok) begin
        len <= len + LEN_ONE;
      end

      if (clr) begin
        len  <= '0;
        ptr  <= '0;
        dir  <= DIR_UP;
        done <= 1'b0;
      end else if (!run) begin
        ptr  <= '0;
        dir  <= DIR_UP;
        done <= 1'b0;
      end else if (!run_q) begin
        dir  <= DIR_UP;
        done <= 1'b0;
        ptr  <= (mode == MODE_REV && has_steps) ? len_m1[ADDRESS_SIZE-1:0] : '0;
      end else if (step_tick && has_steps && !done) begin
        case (mode)
          MODE_FWD: begin
            ptr <= at_end ? '0 : ptr + PTR_ONE;
          end
          MODE_REV: begin
            ptr <= (ptr == '0) ? len_m1[ADDRESS_SIZE-1:0] : ptr - PTR_ONE;
          end
          MODE_PING: begin
            if (len == LEN_ONE) begin
              ptr <= '0;
            end else if (dir == DIR_UP) begin
              if (at_end) begin
                dir <= DIR_DOWN;
                ptr <= ptr - PTR_ONE;
              end else begin
                ptr <= ptr + PTR_ONE;
              end
            end else begin
              if (ptr == '0) begin
                dir <= DIR_UP;
                ptr <= PTR_ONE;
              end else begin
                ptr <= ptr - PTR_ONE;
              end
            end
          end
          MODE_ONESHOT: begin
            if (at_end) begin
              done <= 1'b1;
            end else begin
              ptr <= ptr + PTR_ONE;
            end
          end
          default: begin
            ptr <= ptr;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: multi-channel record/playback step sequencer.
// Ports:
//   clock, Reset   : system clock, async active-low reset
//   step_tick      : shared playback advance strobe
//   store          : debounced store level (edge-detected here)
//   clear          : empties the selected channel
//   channel_sel    : channel addressed by store/clear/status
//   sequence_word  : step value to record (`sequence` is a reserved word)
//   mode, run      : playback mode and enable, shared by all channels
//   display        : per-channel current step, channel n at [n*WORD_SIZE +: WORD_SIZE]
//   length, full   : recorded length of the selected channel and its full flag
//   playing        : per-channel stepping flag
//   store_ack      : pulses the cycle after an accepted store
module pattern_sequencer
  import sequencer_pkg::*;
#(
  parameter int WORD_SIZE    = 2,
  parameter int ADDRESS_SIZE = 4,
  parameter int MEMORY_QTY   = 16,
  parameter int CHANNELS     = 2,
  parameter int CH_BITS      = 1
) (
  input  logic                          clock,
  input  logic                          Reset,
  input  logic                          step_tick,
  input  logic                          store,
  input  logic                          clear,
  input  logic [CH_BITS-1:0]            channel_sel,
  input  logic [WORD_SIZE-1:0]          sequence_word,
  input  logic [1:0]                    mode,
  input  logic                          run,
  output logic [CHANNELS*WORD_SIZE-1:0] display,
  output logic [ADDRESS_SIZE:0]         length,
  output logic                          full,
  output logic [CHANNELS-1:0]           playing,
  output logic                          store_ack
);

  localparam logic [ADDRESS_SIZE:0] LEN_FULL = (ADDRESS_SIZE+1)'(MEMORY_QTY);

  logic                  store_q;
  logic                  store_edge;
  logic                  store_take;
  logic [ADDRESS_SIZE:0] len_all [CHANNELS];
  logic [ADDRESS_SIZE:0] len_sel;
  logic [CHANNELS-1:0]   sel_hit;
  logic [CHANNELS-1:0]   wr_vec;
  logic [CHANNELS-1:0]   clr_vec;

  always_comb begin
    len_sel = '0;
    sel_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (channel_sel == CH_BITS'(i)) begin
        len_sel    = len_all[i];
        sel_hit[i] = 1'b1;
      end
    end
  end

  // Clear beats a coincident store; a full or unmapped channel drops it.
  assign store_edge = store & ~store_q;
  assign store_take = store_edge & ~clear & (|sel_hit) & (len_sel != LEN_FULL);
  assign wr_vec     = sel_hit & {CHANNELS{store_take}};
  assign clr_vec    = sel_hit & {CHANNELS{clear}};

  assign length = len_sel;
  assign full   = (len_sel == LEN_FULL);

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      store_q   <= 1'b0;
      store_ack <= 1'b0;
    end else begin
      store_q   <= store;
      store_ack <= store_take;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    seq_channel #(
      .WORD_SIZE   (WORD_SIZE),
      .ADDRESS_SIZE(ADDRESS_SIZE),
      .MEMORY_QTY  (MEMORY_QTY)
    ) u_ch (
      .clock    (clock),
      .Reset    (Reset),
      .step_tick(step_tick),
      .wr_en    (wr_vec[g]),
      .wr_data  (sequence_word),
      .clr      (clr_vec[g]),
      .run      (run),
      .mode     (mode_t'(mode)),
      .display  (display[g*WORD_SIZE +: WORD_SIZE]),
      .len      (len_all[g]),
      .playing  (playing[g])
    );
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
module tb_pattern_sequencer;

  logic       clock = 1'b0;
  logic       Reset = 1'b0;
  logic       step_tick = 1'b0;
  logic       store = 1'b0;
  logic       clear = 1'b0;
  logic [0:0] channel_sel = '0;
  logic [1:0] sequence_word = '0;
  logic [1:0] mode = '0;
  logic       run = 1'b0;
  logic [3:0] display;
  logic [4:0] length;
  logic       full;
  logic [1:0] playing;
  logic       store_ack;

  pattern_sequencer dut (
    .clock        (clock),
    .Reset        (Reset),
    .step_tick    (step_tick),
    .store        (store),
    .clear        (clear),
    .channel_sel  (channel_sel),
    .sequence_word(sequence_word),
    .mode         (mode),
    .run          (run),
    .display      (display),
    .length       (length),
    .full         (full),
    .playing      (playing),
    .store_ack    (store_ack)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] disp;
    logic [4:0] len;
    logic       full;
    logic [1:0] playing;
    logic       ack;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  // Reference model: recorded steps per channel and a playback position.
  logic [1:0] mem_m [2][16];
  int  len_m [2];
  int  p_m   [2];
  int  k_m   [2];
  bit  done_m[2];
  bit  run_prev_m;
  bit  store_prev_m;

  task automatic check(string name, logic [31:0] got, logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, expv);
    end
  endtask

  function automatic int pp_pos(int k, int len);
    int period;
    int m;
    if (len <= 1) return 0;
    period = 2 * (len - 1);
    m = k % period;
    return (m < len) ? m : period - m;
  endfunction

  // Predict the outputs seen after the coming rising edge, given current inputs.
  task automatic model_edge();
    exp_t e;
    int   sel;
    int   l;
    bit   acc;
    e.cyc = cyc + 1;
    e.disp = '0;
    e.playing = '0;
    if (!Reset) begin
      for (int ch = 0; ch < 2; ch++) begin
        len_m[ch] = 0; p_m[ch] = 0; k_m[ch] = 0; done_m[ch] = 0;
      end
      run_prev_m = 0;
      store_prev_m = 0;
      e.ack = 0;
    end else begin
      sel = int'(channel_sel);
      acc = store && !store_prev_m && !clear && (len_m[sel] < 16);
      for (int ch = 0; ch < 2; ch++) begin
        l = len_m[ch];
        if (run && run_prev_m && l > 0) e.disp[ch*2 +: 2] = mem_m[ch][p_m[ch]];
        if (clear && sel == ch) begin
          len_m[ch] = 0; p_m[ch] = 0; k_m[ch] = 0; done_m[ch] = 0;
        end else begin
          if (!run) begin
            p_m[ch] = 0; k_m[ch] = 0; done_m[ch] = 0;
          end else if (!run_prev_m) begin
            k_m[ch] = 0; done_m[ch] = 0;
            p_m[ch] = (mode == 2'd1 && l > 0) ? l - 1 : 0;
          end else if (step_tick && l > 0 && !done_m[ch]) begin
            case (mode)
              2'd0: p_m[ch] = (p_m[ch] + 1) % l;
              2'd1: p_m[ch] = (p_m[ch] + l - 1) % l;
              2'd2: begin k_m[ch]++; p_m[ch] = pp_pos(k_m[ch], l); end
              default: if (p_m[ch] == l - 1) done_m[ch] = 1; else p_m[ch]++;
            endcase
          end
          if (acc && sel == ch) begin
            mem_m[ch][l] = sequence_word;
            len_m[ch] = l + 1;
          end
        end
      end
      e.ack = acc;
      store_prev_m = store;
      run_prev_m = run;
    end
    sel = int'(channel_sel);
    e.len = 5'(len_m[sel]);
    e.full = (len_m[sel] == 16);
    for (int ch = 0; ch < 2; ch++)
      e.playing[ch] = run && len_m[ch] > 0 && !done_m[ch];
    sbq.push_back(e);
  endtask

  // Called at a negedge with inputs set; pulses drop at the next negedge.
  task automatic step();
    model_edge();
    @(negedge clock);
    step_tick = 1'b0;
    clear = 1'b0;
  endtask

  task automatic press(logic [1:0] v);
    sequence_word = v;
    store = 1'b1;
    step();
    store = 1'b0;
    step();
  endtask

  task automatic ticks(int n, int gap);
    for (int i = 0; i < n; i++) begin
      step_tick = 1'b1;
      step();
      for (int j = 1; j < gap; j++) step();
    end
  endtask

  // Monitor: pops the expectation scheduled for this edge and compares.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        check("schedule", e.cyc, cyc);
        check("display", display, e.disp);
        check("length", length, e.len);
        check("full", full, e.full);
        check("playing", playing, e.playing);
        check("store_ack", store_ack, e.ack);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clock);
    repeat (3) step();
    Reset = 1'b1;
    step();

    // record: four presses, fill to 16, 17th dropped
    channel_sel = 1'b0;
    mode = 2'd0;
    for (int i = 0; i < 4; i++) press(2'($urandom));
    for (int i = 0; i < 12; i++) press(2'($urandom));
    press(2'($urandom));

    // clear; holding store writes one step
    clear = 1'b1;
    step();
    step();
    sequence_word = 2'($urandom);
    store = 1'b1;
    repeat (3) step();
    store = 1'b0;
    step();
    press(2'($urandom));
    press(2'($urandom));

    // forward with wrap
    run = 1'b1;
    step();
    step();
    ticks(5, 4);
    run = 1'b0;
    repeat (2) step();

    // reverse and ping-pong on ch1
    channel_sel = 1'b1;
    for (int i = 0; i < 4; i++) press(2'($urandom));
    mode = 2'd1;
    run = 1'b1;
    step();
    ticks(5, 4);
    run = 1'b0;
    step();
    mode = 2'd2;
    run = 1'b1;
    step();
    ticks(8, 3);
    run = 1'b0;
    step();

    // one-shot and restart
    mode = 2'd3;
    run = 1'b1;
    step();
    ticks(8, 2);
    run = 1'b0;
    step();
    run = 1'b1;
    repeat (2) step();
    ticks(2, 2);
    run = 1'b0;
    step();

    // store during forward playback extends the loop
    channel_sel = 1'b0;
    mode = 2'd0;
    run = 1'b1;
    step();
    ticks(2, 3);
    press(2'($urandom));
    ticks(6, 3);
    run = 1'b0;
    step();

    // clear and store edge together: clear wins
    channel_sel = 1'b1;
    sequence_word = 2'($urandom);
    store = 1'b1;
    clear = 1'b1;
    step();
    store = 1'b0;
    repeat (3) step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step_tick = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 19) == 0) begin
        run = ~run;
        if (!run) mode = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 7) == 0) channel_sel = 1'($urandom);
      if ($urandom_range(0, 3) == 0) store = ~store;
      if (run && mode == 2'd2) store = 1'b0;
      clear = ($urandom_range(0, 39) == 0);
      sequence_word = 2'($urandom);
      step();
    end

    // async reset mid-play
    run = 1'b0;
    mode = 2'd0;
    channel_sel = 1'b0;
    step_tick = 1'b0;
    clear = 1'b0;
    store = 1'b0;
    step();
    press(2'($urandom));
    press(2'($urandom));
    run = 1'b1;
    step();
    ticks(3, 2);
    #2;
    Reset = 1'b0;
    #1;
    check("rst_display", display, 4'd0);
    check("rst_length", length, 5'd0);
    check("rst_full", full, 1'b0);
    check("rst_playing", playing, 2'd0);
    check("rst_store_ack", store_ack, 1'b0);
    step();
    step();
    Reset = 1'b1;
    repeat (3) step();
    run = 1'b0;
    step();

    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clock);
    check("drain", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
Multi-channel record/playback step sequencer, the parametrised successor to the single-channel store/sequencer/memory chain. Each of CHANNELS channels owns a MEMORY_QTY-deep pattern buffer of WORD_SIZE steps. Patterns are recorded one step per debounced store press into the channel picked by channel_sel. All channels then play back in parallel on a shared step tick from the clock divider, in one of four selectable modes.

Parameters:
WORD_SIZE, 2, bits per step.
ADDRESS_SIZE, 4, pointer width; MEMORY_QTY <= 2**ADDRESS_SIZE is required.
MEMORY_QTY, 16, maximum steps per channel.
CHANNELS, 2, number of independent channels (>=1).
CH_BITS, 1, channel_sel width; must satisfy 2**CH_BITS >= CHANNELS.

Ports:
clock  in  1  system clock; all logic on its rising edge.
Reset  in  1  asynchronous active-low reset.
step_tick  in  1  one-clock-wide strobe from the clock divider that advances playback.
store  in  1  debounced store level; the block edge-detects it internally.
clear  in  1  one-cycle pulse; empties the selected channel.
channel_sel  in  CH_BITS  channel targeted by store, clear and the status outputs.
sequence  in  WORD_SIZE  step value to record.
mode  in  2  playback mode: 00 forward loop, 01 reverse loop, 10 ping-pong, 11 one-shot forward.
run  in  1  playback enable.
display  out  CHANNELS*WORD_SIZE  current step of each channel; channel n occupies bits [n*WORD_SIZE +: WORD_SIZE].
length  out  ADDRESS_SIZE+1  number of recorded steps in the selected channel.
full  out  1  selected channel length == MEMORY_QTY.
playing  out  CHANNELS  per-channel flag: actively stepping.
store_ack  out  1  one-cycle pulse when a store is accepted.

Behaviour:
- Reset (Reset low, async):
  - display=0, length counters=0, full=0, playing=0, store_ack=0.
  - Pointers=0, direction=up, store edge register=0, one-shot done flags=0.
  - Memory contents are not reset; playback is gated by length, so unwritten entries are never displayed.
- Record:
  - A rising edge of store (store=1, previous sample=0) writes sequence to mem[ch][len[ch]] and increments len[ch].
  - store_ack pulses in the cycle after the edge.
  - If len[ch]==MEMORY_QTY the store is dropped: no write, no ack.
  - Holding store high writes exactly one step.
- Clear: sets len[ch]=0, ptr[ch]=0, dir=up and clears the done flag. If clear and a store edge occur in the same cycle, clear wins and the store is dropped.
- Playback, per channel, evaluated on each step_tick while run=1 and len>0:
  - Forward: ptr increments, wrapping len-1 -> 0.
  - Reverse: ptr decrements, wrapping 0 -> len-1.
  - Ping-pong: bounces without repeating the end steps (0,1,..,len-1,len-2,..,1,0,1...). For len==1, ptr stays 0.
  - One-shot: increments until ptr==len-1, then sets done; playing drops and display holds the last step. done clears when run falls.
- Read latency: display[ch] is registered as mem[ptr]. It updates exactly one clock after a pointer change, or one clock after the run rise.
- Outputs when idle:
  - len==0 or run=0: display[ch]=0 and playing[ch]=0.
  - Otherwise playing[ch]=run & (len>0) & ~done.
- Run edges:
  - run falling: ptr=0, dir=up, done=0.
  - run rising: ptr starts at 0 in forward, ping-pong and one-shot modes, and at len-1 in reverse. The first step is shown one cycle after the rise, before any tick.
- Mode change during play takes effect on the next tick; ptr is preserved and only the step rule changes.
- Store while the same channel plays: the new length governs wrap from the next tick. A same-cycle write and read of one address returns the old data.
- If len shrinks below ptr+1 through clear, ptr has already been forced to 0.
- Ticks while run=0 are ignored. A tick coincident with a run rise is ignored.
- Width rules:
  - len is ADDRESS_SIZE+1 bits so the full count is representable.
  - Pointer compares use len-1 computed at ADDRESS_SIZE+1 bits; no truncation.

Decomposition:
- Shared package sequencer_pkg holds:
  - Mode constants MODE_FWD, MODE_REV, MODE_PING, MODE_ONESHOT.
  - The 2-bit mode typedef.
- Sub-module seq_channel: one channel's memory, len counter, pointer/direction/done FSM and registered read. Instantiate CHANNELS copies via generate.
- The top level holds the store edge detect, the channel_sel demux, the status mux and store_ack.

Test Plan:
- Store edge and full: reset, ch0, store 1,2,3,0 -> len=4, four store_ack pulses. Then 12 more presses -> full=1. A 17th press -> no ack, len stays 16.
- Forward with wrap: ch0 holds 1,2,3 in forward mode, run=1, tick every 4 cycles -> display[1:0] = 1,2,3,1,2. Each value changes one cycle after its tick.
- Reverse and ping-pong: ch1 holds 0,1,2,3.
  - Reverse: display[3:2] = 3,2,1,0,3.
  - Ping-pong: display[3:2] = 0,1,2,3,2,1,0,1.
- One-shot and restart: 3 steps in one-shot mode -> 1,2,3, then playing[0]=0 and 3 holds across 5 more ticks. Dropping and re-raising run -> shows 1 again.
- Simultaneous events: clear and a store edge in the same cycle -> len=0, no ack, display=0.
  - Store during playback extends the loop from the next wrap.
- Async reset mid-play: drive Reset low between clock edges -> all outputs 0 immediately. After release, len=0 and display=0.
